// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulation controller.
//   psum_state_t : controller FSM encoding (IDLE -> ACC -> DONE -> IDLE)
//   max_w        : larger of two widths. The adder and its bench use it to size
//                  the internal sign-extension path.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } psum_state_t;

    function automatic int max_w(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_adder.sv
// Adder_ideal: combinational signed adder, Sum = sext(A) + B + Carry, wrapped
// modulo 2**WIDTH_B. Overflow detection is left to the caller, which knows
// which operand is the running accumulator.
//   A     in  WIDTH_A  signed operand, sign-extended to WIDTH_B
//   B     in  WIDTH_B  signed operand (accumulator)
//   Carry in  1        carry-in / rounding bit
//   Sum   out WIDTH_B  wrapped sum
module Adder_ideal
    import psum_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 8
) (
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic               Carry,
    output logic [WIDTH_B-1:0] Sum
);

    localparam int EXT_W = max_w(WIDTH_A, WIDTH_B);

    generate
        if (WIDTH_B < WIDTH_A) begin : g_width_chk
            $error("Adder_ideal: WIDTH_B must be >= WIDTH_A");
        end
    endgenerate

    logic [EXT_W-1:0] a_ext;
    logic [EXT_W-1:0] sum_full;

    // Sign extension: bits above WIDTH_A replicate the operand's sign bit.
    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_sext
            if (gi < WIDTH_A) begin : g_low
                assign a_ext[gi] = A[gi];
            end else begin : g_high
                assign a_ext[gi] = A[WIDTH_A-1];
            end
        end
    endgenerate

    assign sum_full = a_ext + EXT_W'(B) + EXT_W'(Carry);
    assign Sum      = sum_full[WIDTH_B-1:0];

endmodule

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: accumulates a burst of signed operands into one wrapped
// partial sum, using the shared Adder_ideal. The sticky overflow flag is set
// if any beat overflowed the signed range.
//   clk, rst_n           clock, asynchronous active-low reset
//   start, len, flush    burst control (start/len honoured in IDLE; flush always)
//   busy                 high in ACC or DONE
//   in_valid/in_ready    operand stream, one beat per cycle
//   in_data, in_carry    signed operand and its carry-in
//   out_valid/out_ready  result handshake
//   out_sum, out_ovf     result (zero outside DONE)
module psum_accum_ctrl
    import psum_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 8,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               flush,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] in_data,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_B-1:0] out_sum,
    output logic               out_ovf
);

    psum_state_t        state_q, state_d;
    logic [WIDTH_B-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH_B-1:0] sum;
    logic               beat;
    logic               beat_ovf;

    Adder_ideal #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_adder (
        .A     (in_data),
        .B     (acc_q),
        .Carry (in_carry),
        .Sum   (sum)
    );

    assign beat = (state_q == ACC) && in_valid;

    // Signed overflow: both addends share a sign and the result's sign differs.
    // The carry-in is part of the result, so 127 + 0 + 1 counts as overflow.
    assign beat_ovf = (in_data[WIDTH_A-1] == acc_q[WIDTH_B-1]) &&
                      (sum[WIDTH_B-1] != acc_q[WIDTH_B-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (flush) begin
            // Abort takes priority over start, a beat, and out_ready.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        if (len != '0) begin
                            state_d = ACC;
                            cnt_d   = len;
                        end else begin
                            // An empty burst goes straight to a zero result.
                            state_d = DONE;
                            cnt_d   = '0;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = sum;
                        cnt_d = cnt_q - LEN_W'(1);
                        ovf_d = ovf_q | beat_ovf;
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // Start is not looked at here, so a new burst can begin
                    // only in the cycle after the result is taken.
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ACC) || (state_q == DONE);
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = (state_q == DONE) ? acc_q : '0;
    assign out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
module tb_psum_accum_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       flush;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_carry;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    psum_accum_ctrl #(.WIDTH_A(4), .WIDTH_B(8), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .flush     (flush),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; len = 0; flush = 0; in_valid = 0;
        in_data = 0; in_carry = 0; out_ready = 0;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1; len = l;
        step();
        start = 0; len = 0;
    endtask

    task automatic beat(input logic [3:0] d, input logic c);
        in_valid = 1; in_data = d; in_carry = c;
        step();
        in_valid = 0; in_data = 0; in_carry = 0;
    endtask

    task automatic take_result();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #2;
        checks++;
        if ({busy, in_ready, out_valid, out_sum, out_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b rdy=%0b vld=%0b sum=%h ovf=%0b, need all 0",
                     busy, in_ready, out_valid, out_sum, out_ovf);
        end
        step();
        rst_n = 1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b need 0", busy);
        end
        $display("test_reset: busy=%0b out_valid=%0b", busy, out_valid);
    endtask

    task automatic test_basic();
        do_start(8'd3);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_acc: in_ready=%0b busy=%0b need 1 1", in_ready, busy);
        end
        beat(4'h5, 0);
        beat(4'hD, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: out_valid=%0b need 0 after 2 beats", out_valid);
        end
        beat(4'h7, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h09 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: vld=%0b sum=%h ovf=%0b rdy=%0b need 1 09 0 0",
                     out_valid, out_sum, out_ovf, in_ready);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: vld=%0b sum=%h busy=%0b need 0 00 0", out_valid, out_sum, busy);
        end
        $display("test_basic: len=3 5,-3,7 sum=9");
    endtask

    task automatic test_carry();
        do_start(8'd2);
        beat(4'hF, 1);
        beat(4'hF, 1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_sum: vld=%0b sum=%h ovf=%0b need 1 00 0", out_valid, out_sum, out_ovf);
        end
        take_result();
        $display("test_carry: len=2 -1+1,-1+1 sum=0");
    endtask

    task automatic test_wrap();
        do_start(8'd20);
        for (int i = 0; i < 20; i++) beat(4'h7, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h8C || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sum: vld=%0b sum=%h ovf=%0b need 1 8c 1", out_valid, out_sum, out_ovf);
        end
        take_result();
        $display("test_wrap: len=20 x7 sum=-116 ovf=1");
    endtask

    // 18 x 7 = 126, +0+1 = 127 (no overflow), +0+1 = -128 (carry alone overflows).
    task automatic test_carry_ovf();
        do_start(8'd19);
        for (int i = 0; i < 18; i++) beat(4'h7, 0);
        beat(4'h0, 1);
        checks++;
        if (out_sum !== 8'h7F || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_no_ovf: sum=%h ovf=%0b need 7f 0", out_sum, out_ovf);
        end
        take_result();
        do_start(8'd20);
        for (int i = 0; i < 18; i++) beat(4'h7, 0);
        beat(4'h0, 1);
        beat(4'h0, 1);
        checks++;
        if (out_sum !== 8'h80 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL carry_ovf: sum=%h ovf=%0b need 80 1", out_sum, out_ovf);
        end
        take_result();
        $display("test_carry_ovf: 127+0+1 flags overflow");
    endtask

    task automatic test_zero_len();
        do_start(8'd0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: vld=%0b sum=%h rdy=%0b busy=%0b need 1 00 0 1",
                     out_valid, out_sum, in_ready, busy);
        end
        take_result();
        $display("test_zero_len: immediate empty result");
    endtask

    task automatic test_stall();
        do_start(8'd4);
        beat(4'h1, 0);
        step();
        beat(4'h2, 0);
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_gap: rdy=%0b vld=%0b need 1 0", in_ready, out_valid);
        end
        beat(4'h3, 0);
        beat(4'h4, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 8'd9;
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'h0A || out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld=%0b sum=%h ovf=%0b need 1 0a 0",
                         i, out_valid, out_sum, out_ovf);
            end
            step();
        end
        // Start in the same cycle as out_ready must be ignored.
        start = 1; len = 8'd9; out_ready = 1;
        step();
        start = 0; len = 0; out_ready = 0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: busy=%0b vld=%0b need 0 0", busy, out_valid);
        end
        do_start(8'd1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_restart: rdy=%0b need 1", in_ready);
        end
        beat(4'h3, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h03) begin
            errors++;
            $display("FAIL stall_next: vld=%0b sum=%h need 1 03", out_valid, out_sum);
        end
        take_result();
        $display("test_stall: gaps, held result, ignored start, restart");
    endtask

    task automatic test_flush_reset();
        do_start(8'd4);
        beat(4'h1, 0);
        beat(4'h1, 0);
        flush = 1; in_valid = 1; in_data = 4'h1;
        step();
        flush = 0; in_valid = 0; in_data = 0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle: busy=%0b rdy=%0b vld=%0b need 0 0 0", busy, in_ready, out_valid);
        end
        do_start(8'd2);
        beat(4'h5, 0);
        rst_n = 0;
        #1;
        checks++;
        if ({busy, in_ready, out_valid, out_sum, out_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: busy=%0b rdy=%0b vld=%0b sum=%h ovf=%0b need all 0",
                     busy, in_ready, out_valid, out_sum, out_ovf);
        end
        step();
        rst_n = 1;
        step();
        do_start(8'd1);
        beat(4'hC, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'hFC || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: vld=%0b sum=%h ovf=%0b need 1 fc 0", out_valid, out_sum, out_ovf);
        end
        // Flush in DONE beats both out_ready and start.
        flush = 1; start = 1; len = 8'd3; out_ready = 1;
        step();
        flush = 0; start = 0; len = 0; out_ready = 0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: busy=%0b vld=%0b need 0 0", busy, out_valid);
        end
        $display("test_flush_reset: flush, async reset, sum=-4");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_wrap();
        test_carry_ovf();
        test_zero_len();
        test_stall();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
